fp_sgnj_pipe: RTL and testbench
===============================

Name: fp_sgnj_pipe

Overview:
- Parametrised, pipelined floating-point sign-injection unit for the Floating ALU.
- Implements FSGNJ, FSGNJN and FSGNJX for any FLEN (32 single, 64 double).
- Elastic valid/ready pipeline of DEPTH stages with full-throughput backpressure handling.
- A transaction tag rides alongside each result so the ALU issue logic can match results to requests.

Parameters:
- FLEN, 32, operand/result width; sign bit is bit FLEN-1.
- DEPTH, 2, number of register stages (1..4); fixed latency in cycles.
- TAG_W, 4, width of the pass-through transaction tag.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  request present.
- in_ready  output  1  unit can accept a request this cycle.
- funct  input  2  00=SGNJ, 01=SGNJN, 10=SGNJX, 11=illegal.
- rs1  input  FLEN  magnitude source.
- rs2  input  FLEN  sign source.
- in_tag  input  TAG_W  request tag.
- out_valid  output  1  result present.
- out_ready  input  1  consumer accepts result.
- rd  output  FLEN  result.
- out_tag  output  TAG_W  tag of the result.
- out_illegal  output  1  result came from funct=11.

Behaviour:
- Result function, evaluated combinationally at the input before stage 0:
  - rd[FLEN-2:0] = rs1[FLEN-2:0] in all modes.
  - Sign: SGNJ = rs2[FLEN-1]; SGNJN = ~rs2[FLEN-1]; SGNJX = rs1[FLEN-1] ^ rs2[FLEN-1].
  - funct=11: rd = rs1 unchanged, out_illegal=1. In every other mode out_illegal=0.
- No exceptions or flags are raised. NaN, Inf, zero and denormal operands are treated as raw bits; NaN payloads are preserved.
- Storage: stages s[0..DEPTH-1], each holding {v, rd, tag, illegal}. Stage DEPTH-1 drives the outputs.
- Ready chain (combinational):
  - rdy[DEPTH-1] = ~v[DEPTH-1] | out_ready.
  - rdy[i] = ~v[i] | rdy[i+1].
  - in_ready = rdy[0].
- Stage updates:
  - When rdy[0]: s[0] loads {in_valid, computed fields}. Fields may load even when in_valid=0.
  - For i>0, when rdy[i]: s[i] loads s[i-1].
  - A stage with rdy=0 holds all of its contents.
- Input accept = in_valid & in_ready. Output transfer = out_valid & out_ready.
- Latency: exactly DEPTH cycles from accept to out_valid when there is no backpressure. Throughput is one op per cycle while out_ready=1.
- Backpressure: with out_ready=0, the pipeline fills to DEPTH entries, then in_ready drops in the same cycle that the input-side stage is occupied and blocked.
  - rd, out_tag and out_illegal stay stable while out_valid=1 and out_ready=0.
  - No result is dropped or duplicated.
- Full pipeline with out_ready=1 and in_valid=1: accept and transfer occur in the same cycle, everything advances, in_ready stays 1.
- Empty pipeline: out_valid=0. rd/out_tag/out_illegal are don't-care but must not be X after reset.
- Reset (rst=1 at a clock edge):
  - All v cleared; all rd/tag/illegal cleared to 0.
  - out_valid=0, rd=0, out_tag=0, out_illegal=0.
  - in_ready=1 from the first cycle after reset.
- Reset mid-operation: in-flight results are discarded without being presented. An input offered in the reset cycle is not accepted.
- DEPTH outside 1..4 is a configuration error; flag it at elaboration.

Test Plan:
- SGNJ, FLEN=32, DEPTH=2: rs1=0x40866666 (4.2), rs2=0xBF000000 (-0.5), tag=3 -> after 2 cycles rd=0xC0866666, out_tag=3, out_illegal=0.
- SGNJN/SGNJX back-to-back, out_ready=1:
  - SGNJN on the same operands -> rd=0x40866666.
  - Next cycle, SGNJX with rs1=0xC0CCCCCC, rs2=0xBF000000 -> rd=0x40CCCCCC.
  - Results appear on consecutive cycles.
- Illegal funct=11: rs1=0x7FC00001 (NaN), rs2=0x80000000 -> rd=0x7FC00001, out_illegal=1.
- Backpressure: hold out_ready=0 and stream 4 ops (tags 0..3) -> in_ready=0 after 2 accepts. Release out_ready -> tags 0,1,2,3 appear in order with none lost, rd stable while stalled.
- FLEN=64, DEPTH=3: SGNJX with rs1=0x3FF0000000000000, rs2=0x8000000000000000 -> rd=0xBFF0000000000000 after 3 cycles.
- Reset mid-flight: accept 2 ops, assert rst for one cycle -> out_valid=0 and rd=0 next cycle, in_ready=1, and no stale result ever emerges.

Source files
------------

// File: rtl/fp_sgnj_pipe_if.sv
// Request/response bundle for the sign-injection pipeline.
// The requester uses master; the pipeline uses slave.
interface fp_sgnj_pipe_if #(
  parameter int unsigned FLEN  = 32,
  parameter int unsigned TAG_W = 4
);
  logic             in_valid;
  logic             in_ready;
  logic [1:0]       funct;
  logic [FLEN-1:0]  rs1;
  logic [FLEN-1:0]  rs2;
  logic [TAG_W-1:0] in_tag;
  logic             out_valid;
  logic             out_ready;
  logic [FLEN-1:0]  rd;
  logic [TAG_W-1:0] out_tag;
  logic             out_illegal;

  modport master (
    output in_valid, funct, rs1, rs2, in_tag, out_ready,
    input  in_ready, out_valid, rd, out_tag, out_illegal
  );

  modport slave (
    input  in_valid, funct, rs1, rs2, in_tag, out_ready,
    output in_ready, out_valid, rd, out_tag, out_illegal
  );
endinterface

// File: rtl/fp_sgnj_pipe.sv
// Pipelined FSGNJ/FSGNJN/FSGNJX unit with an elastic valid/ready chain.
// The result is formed before stage 0; later stages only carry it and its tag.
module fp_sgnj_pipe #(
  parameter int unsigned FLEN  = 32,
  parameter int unsigned DEPTH = 2,
  parameter int unsigned TAG_W = 4
) (
  input  logic          clk,
  input  logic          rst,
  fp_sgnj_pipe_if.slave bus
);

  if (DEPTH == 0 || DEPTH > 4) begin : g_bad_depth
    $error("fp_sgnj_pipe: DEPTH must be in 1..4");
  end
  if (FLEN < 2) begin : g_bad_flen
    $error("fp_sgnj_pipe: FLEN must be at least 2");
  end

  logic             sign_in;
  logic             ill_in;
  logic [FLEN-1:0]  rd_in;

  logic [DEPTH-1:0] rdy;
  logic             all_full;

  logic [DEPTH-1:0] v_q, v_d;
  logic [FLEN-1:0]  rd_q  [DEPTH];
  logic [FLEN-1:0]  rd_d  [DEPTH];
  logic [TAG_W-1:0] tag_q [DEPTH];
  logic [TAG_W-1:0] tag_d [DEPTH];
  logic [DEPTH-1:0] ill_q, ill_d;

  // Sign selection; the illegal encoding passes rs1 through untouched.
  always_comb begin
    sign_in = bus.rs1[FLEN-1];
    ill_in  = 1'b0;
    unique case (bus.funct)
      2'b00: sign_in = bus.rs2[FLEN-1];
      2'b01: sign_in = ~bus.rs2[FLEN-1];
      2'b10: sign_in = bus.rs1[FLEN-1] ^ bus.rs2[FLEN-1];
      2'b11: ill_in  = 1'b1;
    endcase
    rd_in = {sign_in, bus.rs1[FLEN-2:0]};
  end

  // Stage i may load unless it and every stage after it are full and the
  // consumer is stalling; this is the unrolled form of the ready chain.
  always_comb begin
    rdy      = '0;
    all_full = 1'b1;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      all_full = 1'b1;
      for (int unsigned j = i; j < DEPTH; j++) begin
        all_full = all_full & v_q[j];
      end
      rdy[i] = ~all_full | bus.out_ready;
    end
  end

  // Next state: each ready stage takes its upstream neighbour, stage 0 takes the input.
  always_comb begin
    v_d   = v_q;
    rd_d  = rd_q;
    tag_d = tag_q;
    ill_d = ill_q;
    for (int unsigned i = 1; i < DEPTH; i++) begin
      if (rdy[i]) begin
        v_d[i]   = v_q[i-1];
        rd_d[i]  = rd_q[i-1];
        tag_d[i] = tag_q[i-1];
        ill_d[i] = ill_q[i-1];
      end
    end
    if (rdy[0]) begin
      v_d[0]   = bus.in_valid;
      rd_d[0]  = rd_in;
      tag_d[0] = bus.in_tag;
      ill_d[0] = ill_in;
    end
  end

  // Stage registers; reset clears data too so outputs are never X.
  always_ff @(posedge clk) begin
    if (rst) begin
      v_q   <= '0;
      rd_q  <= '{default: '0};
      tag_q <= '{default: '0};
      ill_q <= '0;
    end else begin
      v_q   <= v_d;
      rd_q  <= rd_d;
      tag_q <= tag_d;
      ill_q <= ill_d;
    end
  end

  assign bus.in_ready    = rdy[0];
  assign bus.out_valid   = v_q[DEPTH-1];
  assign bus.rd          = rd_q[DEPTH-1];
  assign bus.out_tag     = tag_q[DEPTH-1];
  assign bus.out_illegal = ill_q[DEPTH-1];

endmodule

// File: tb/tb_fp_sgnj_pipe.sv
// Bench for fp_sgnj_pipe: a 32-bit/DEPTH=2 and a 64-bit/DEPTH=3 instance,
// directed cases plus random traffic against a queue-based reference model.
module tb_fp_sgnj_pipe;
  localparam int unsigned TagW = 4;

  typedef struct {
    logic [63:0]     rd;
    logic [TagW-1:0] tag;
    logic            ill;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  fp_sgnj_pipe_if #(.FLEN(32), .TAG_W(TagW)) bus_a ();
  fp_sgnj_pipe_if #(.FLEN(64), .TAG_W(TagW)) bus_b ();

  fp_sgnj_pipe #(.FLEN(32), .DEPTH(2), .TAG_W(TagW)) u_dut_a (
    .clk (clk),
    .rst (rst),
    .bus (bus_a)
  );

  fp_sgnj_pipe #(.FLEN(64), .DEPTH(3), .TAG_W(TagW)) u_dut_b (
    .clk (clk),
    .rst (rst),
    .bus (bus_b)
  );

  int unsigned total = 0;
  int unsigned bad   = 0;

  task automatic check_eq(input string name, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h want=%h", name, got, exp);
    end
  endtask

  // Reference: magnitude from rs1, sign chosen by the instruction, raw bits.
  function automatic exp_t ref_op(input int unsigned flen, input logic [1:0] f,
                                  input logic [63:0] a, input logic [63:0] b,
                                  input logic [TagW-1:0] t);
    exp_t        r;
    logic [63:0] sign_mask;
    logic        a_neg, b_neg, neg;
    sign_mask = 64'd1 << (flen - 1);
    a_neg     = (a & sign_mask) != 64'd0;
    b_neg     = (b & sign_mask) != 64'd0;
    neg       = a_neg;
    if (f == 2'd0) neg = b_neg;
    else if (f == 2'd1) neg = !b_neg;
    else if (f == 2'd2) neg = (a_neg != b_neg);
    r.rd  = neg ? (a | sign_mask) : (a & ~sign_mask);
    r.tag = t;
    r.ill = (f == 2'd3);
    return r;
  endfunction

  function automatic logic [63:0] rand64();
    return {$urandom(), $urandom()};
  endfunction

  // Scoreboards: queue length equals the number of results in flight.
  exp_t            q_a[$];
  exp_t            q_b[$];
  exp_t            e_a, e_b;
  logic            stall_a = 1'b0, stall_b = 1'b0;
  logic [63:0]     held_rd_a, held_rd_b;
  logic [TagW-1:0] held_tag_a, held_tag_b;
  logic [TagW-1:0] tag_log[$];
  logic            log_en = 1'b0;

  always @(negedge clk) begin
    if (rst) begin
      q_a.delete();
      stall_a = 1'b0;
    end else begin
      check_eq("a_in_ready", 64'(bus_a.in_ready), 64'((q_a.size() < 2) || bus_a.out_ready));
      if (bus_a.out_valid) begin
        if (q_a.size() == 0) begin
          check_eq("a_stale_valid", 64'(bus_a.out_valid), 64'd0);
        end else begin
          if (stall_a) begin
            check_eq("a_hold_rd", 64'(bus_a.rd), held_rd_a);
            check_eq("a_hold_tag", 64'(bus_a.out_tag), 64'(held_tag_a));
          end
          if (bus_a.out_ready) begin
            e_a = q_a.pop_front();
            check_eq("a_rd", 64'(bus_a.rd), e_a.rd);
            check_eq("a_tag", 64'(bus_a.out_tag), 64'(e_a.tag));
            check_eq("a_illegal", 64'(bus_a.out_illegal), 64'(e_a.ill));
            if (log_en) tag_log.push_back(bus_a.out_tag);
          end
        end
      end
      stall_a    = bus_a.out_valid && !bus_a.out_ready;
      held_rd_a  = 64'(bus_a.rd);
      held_tag_a = bus_a.out_tag;
      if (bus_a.in_valid && bus_a.in_ready)
        q_a.push_back(ref_op(32, bus_a.funct, 64'(bus_a.rs1), 64'(bus_a.rs2), bus_a.in_tag));
    end
  end

  always @(negedge clk) begin
    if (rst) begin
      q_b.delete();
      stall_b = 1'b0;
    end else begin
      check_eq("b_in_ready", 64'(bus_b.in_ready), 64'((q_b.size() < 3) || bus_b.out_ready));
      if (bus_b.out_valid) begin
        if (q_b.size() == 0) begin
          check_eq("b_stale_valid", 64'(bus_b.out_valid), 64'd0);
        end else begin
          if (stall_b) begin
            check_eq("b_hold_rd", bus_b.rd, held_rd_b);
            check_eq("b_hold_tag", 64'(bus_b.out_tag), 64'(held_tag_b));
          end
          if (bus_b.out_ready) begin
            e_b = q_b.pop_front();
            check_eq("b_rd", bus_b.rd, e_b.rd);
            check_eq("b_tag", 64'(bus_b.out_tag), 64'(e_b.tag));
            check_eq("b_illegal", 64'(bus_b.out_illegal), 64'(e_b.ill));
          end
        end
      end
      stall_b    = bus_b.out_valid && !bus_b.out_ready;
      held_rd_b  = bus_b.rd;
      held_tag_b = bus_b.out_tag;
      if (bus_b.in_valid && bus_b.in_ready)
        q_b.push_back(ref_op(64, bus_b.funct, bus_b.rs1, bus_b.rs2, bus_b.in_tag));
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_a(input logic v, input logic [1:0] f, input logic [31:0] a,
                         input logic [31:0] b, input logic [TagW-1:0] t);
    bus_a.in_valid = v;
    bus_a.funct    = f;
    bus_a.rs1      = a;
    bus_a.rs2      = b;
    bus_a.in_tag   = t;
  endtask

  task automatic drive_b(input logic v, input logic [1:0] f, input logic [63:0] a,
                         input logic [63:0] b, input logic [TagW-1:0] t);
    bus_b.in_valid = v;
    bus_b.funct    = f;
    bus_b.rs1      = a;
    bus_b.rs2      = b;
    bus_b.in_tag   = t;
  endtask

  int k;

  initial begin
    rst = 1'b1;
    drive_a(1'b0, 2'd0, 32'd0, 32'd0, '0);
    drive_b(1'b0, 2'd0, 64'd0, 64'd0, '0);
    bus_a.out_ready = 1'b1;
    bus_b.out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    // Reset state
    @(negedge clk);
    check_eq("rst_a_valid", 64'(bus_a.out_valid), 64'd0);
    check_eq("rst_a_rd", 64'(bus_a.rd), 64'd0);
    check_eq("rst_a_tag", 64'(bus_a.out_tag), 64'd0);
    check_eq("rst_a_illegal", 64'(bus_a.out_illegal), 64'd0);
    check_eq("rst_a_in_ready", 64'(bus_a.in_ready), 64'd1);
    check_eq("rst_b_valid", 64'(bus_b.out_valid), 64'd0);
    check_eq("rst_b_rd", bus_b.rd, 64'd0);
    check_eq("rst_b_in_ready", 64'(bus_b.in_ready), 64'd1);
    step();

    // SGNJ with two-cycle latency
    drive_a(1'b1, 2'd0, 32'h40866666, 32'hBF000000, 4'd3);
    step();
    drive_a(1'b0, 2'd0, 32'd0, 32'd0, '0);
    @(negedge clk);
    check_eq("sgnj_early_valid", 64'(bus_a.out_valid), 64'd0);
    step();
    @(negedge clk);
    check_eq("sgnj_valid", 64'(bus_a.out_valid), 64'd1);
    check_eq("sgnj_rd", 64'(bus_a.rd), 64'hC0866666);
    check_eq("sgnj_tag", 64'(bus_a.out_tag), 64'd3);
    check_eq("sgnj_illegal", 64'(bus_a.out_illegal), 64'd0);
    step();

    // SGNJN then SGNJX back to back
    drive_a(1'b1, 2'd1, 32'h40866666, 32'hBF000000, 4'd4);
    step();
    drive_a(1'b1, 2'd2, 32'hC0CCCCCC, 32'hBF000000, 4'd5);
    step();
    drive_a(1'b0, 2'd0, 32'd0, 32'd0, '0);
    @(negedge clk);
    check_eq("sgnjn_valid", 64'(bus_a.out_valid), 64'd1);
    check_eq("sgnjn_rd", 64'(bus_a.rd), 64'h40866666);
    step();
    @(negedge clk);
    check_eq("sgnjx_valid", 64'(bus_a.out_valid), 64'd1);
    check_eq("sgnjx_rd", 64'(bus_a.rd), 64'h40CCCCCC);
    check_eq("sgnjx_tag", 64'(bus_a.out_tag), 64'd5);
    step();

    // Illegal funct keeps NaN payload and flags it
    drive_a(1'b1, 2'd3, 32'h7FC00001, 32'h80000000, 4'd6);
    step();
    drive_a(1'b0, 2'd0, 32'd0, 32'd0, '0);
    step();
    @(negedge clk);
    check_eq("ill_valid", 64'(bus_a.out_valid), 64'd1);
    check_eq("ill_rd", 64'(bus_a.rd), 64'h7FC00001);
    check_eq("ill_flag", 64'(bus_a.out_illegal), 64'd1);
    step();

    // Backpressure: only two accepts fit while the consumer stalls
    bus_a.out_ready = 1'b0;
    tag_log.delete();
    log_en = 1'b1;
    k = 0;
    repeat (6) begin
      drive_a(1'b1, 2'd0, $urandom(), $urandom(), TagW'(k));
      @(negedge clk);
      if (bus_a.in_ready) k++;
      step();
    end
    drive_a(1'b0, 2'd0, 32'd0, 32'd0, '0);
    @(negedge clk);
    check_eq("bp_accepts", 64'(k), 64'd2);
    check_eq("bp_in_ready", 64'(bus_a.in_ready), 64'd0);
    check_eq("bp_out_valid", 64'(bus_a.out_valid), 64'd1);
    step();
    bus_a.out_ready = 1'b1;
    repeat (12) begin
      if (k < 4) drive_a(1'b1, 2'd0, $urandom(), $urandom(), TagW'(k));
      else drive_a(1'b0, 2'd0, 32'd0, 32'd0, '0);
      @(negedge clk);
      if (bus_a.in_valid && bus_a.in_ready) k++;
      step();
    end
    log_en = 1'b0;
    check_eq("bp_total_accepts", 64'(k), 64'd4);
    check_eq("bp_out_count", 64'(tag_log.size()), 64'd4);
    for (int i = 0; i < 4 && i < tag_log.size(); i++)
      check_eq("bp_order", 64'(tag_log[i]), 64'(i));

    // 64-bit SGNJX with three-cycle latency
    drive_b(1'b1, 2'd2, 64'h3FF0000000000000, 64'h8000000000000000, 4'd9);
    step();
    drive_b(1'b0, 2'd0, 64'd0, 64'd0, '0);
    @(negedge clk);
    check_eq("b_lat1_valid", 64'(bus_b.out_valid), 64'd0);
    step();
    @(negedge clk);
    check_eq("b_lat2_valid", 64'(bus_b.out_valid), 64'd0);
    step();
    @(negedge clk);
    check_eq("b_lat3_valid", 64'(bus_b.out_valid), 64'd1);
    check_eq("b_sgnjx_rd", bus_b.rd, 64'hBFF0000000000000);
    check_eq("b_sgnjx_tag", 64'(bus_b.out_tag), 64'd9);
    step();

    // Reset mid-flight: in-flight work and the input offered during reset vanish
    bus_a.out_ready = 1'b0;
    drive_a(1'b1, 2'd0, 32'h11111111, 32'h80000000, 4'd7);
    step();
    drive_a(1'b1, 2'd1, 32'h22222222, 32'h00000000, 4'd8);
    step();
    drive_a(1'b1, 2'd2, 32'h33333333, 32'h80000000, 4'd9);
    rst = 1'b1;
    step();
    rst = 1'b0;
    drive_a(1'b0, 2'd0, 32'd0, 32'd0, '0);
    bus_a.out_ready = 1'b1;
    @(negedge clk);
    check_eq("mid_rst_valid", 64'(bus_a.out_valid), 64'd0);
    check_eq("mid_rst_rd", 64'(bus_a.rd), 64'd0);
    check_eq("mid_rst_in_ready", 64'(bus_a.in_ready), 64'd1);
    repeat (5) begin
      step();
      @(negedge clk);
      check_eq("mid_rst_no_stale", 64'(bus_a.out_valid), 64'd0);
    end
    step();

    // Random traffic on both instances, checked by the scoreboards
    repeat (400) begin
      drive_a(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), $urandom(), $urandom(),
              TagW'($urandom()));
      drive_b(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), rand64(), rand64(),
              TagW'($urandom()));
      bus_a.out_ready = ($urandom_range(0, 3) != 0);
      bus_b.out_ready = ($urandom_range(0, 2) != 0);
      step();
    end

    // Drain and confirm nothing was lost
    drive_a(1'b0, 2'd0, 32'd0, 32'd0, '0);
    drive_b(1'b0, 2'd0, 64'd0, 64'd0, '0);
    bus_a.out_ready = 1'b1;
    bus_b.out_ready = 1'b1;
    repeat (8) step();
    @(negedge clk);
    check_eq("a_drained", 64'(q_a.size()), 64'd0);
    check_eq("b_drained", 64'(q_b.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
